bf_cell_ctrl: RTL and testbench
===============================

# bf_cell_ctrl

Data-cell sequencer for the BF CPU. Accepts one decoded cell/pointer operation at a time (`+`, `-`, `>`, `<`, load) over a valid/ready handshake. It performs the read-modify-write on the data RAM through the 8-bit ALU (`nochange`/`decrement`/`increment`) and maintains the data pointer. It sits between the instruction decoder and the data RAM/ALU pair, and exports `cell_zero` so the loop logic can resolve `[`/`]`.

## Interface

- `ADDR_W`, 8, data-pointer / data-RAM address width.
- `clk` in 1, system clock, rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `op_valid` in 1, operation request.
- `op_code` in 3, 0=NOP, 1=INC, 2=DEC, 3=PTR_INC, 4=PTR_DEC, 5=LOAD, 6–7 treated as NOP.
- `op_ready` out 1, controller can accept; transfer when `op_valid && op_ready`.
- `busy` out 1, equals `!op_ready`.
- `ram_addr` out ADDR_W, data-RAM address; always equals `ptr`.
- `ram_re` out 1, read strobe; `ram_rdata` is valid the cycle after `ram_re`.
- `ram_rdata` in 8, read data.
- `ram_we` out 1, write strobe; RAM writes `ram_wdata` at the rising edge.
- `ram_wdata` out 8, write data; equals `alu_out`.
- `alu_a` out 8, ALU operand; equals the internal cell register.
- `alu_nochange`, `alu_decrement`, `alu_increment` out 1 each, ALU controls; always exactly one high.
- `alu_out` in 8, combinational ALU result.
- `ptr` out ADDR_W, current data pointer.
- `cell_zero` out 1, high when the cell at `ptr` is 0x00.

## Operation

- **States:** IDLE, READ, WAIT, EXEC.
- **IDLE**
  - `op_ready`=1.
  - On transfer, latch `op_code`.
  - INC, DEC or LOAD: go to READ.
  - PTR_INC: `ptr <= ptr+1` (mod 2^ADDR_W), then go to READ.
  - PTR_DEC: `ptr <= ptr-1` (mod 2^ADDR_W), then go to READ.
  - NOP or undefined code: stay in IDLE, no side effects.
- **READ:** `ram_re`=1, `ram_addr`=`ptr`; go to WAIT.
- **WAIT**
  - `cell <= ram_rdata`.
  - LOAD or pointer op: `cell_zero <= (ram_rdata==0)`, go to IDLE.
  - INC or DEC: go to EXEC.
- **EXEC**
  - `alu_increment`=1 for INC, `alu_decrement`=1 for DEC.
  - `ram_we`=1, `ram_wdata`=`alu_out`.
  - `cell <= alu_out`, `cell_zero <= (alu_out==0)`.
  - Go to IDLE.
- **ALU controls outside EXEC:** `alu_nochange`=1, others 0.
- **Arithmetic:** 8-bit modulo, supplied by the ALU: 0xFF+1=0x00, 0x00−1=0xFF. The pointer wraps modulo 2^ADDR_W.
- **Invariant:** after every operation, `cell_zero` reflects the RAM cell at the new `ptr`.
- **Data RAM:** zero-initialized at power-up.
- **Held requests:** `op_code` and `op_valid` are ignored while `op_ready`=0. A request held across that window is accepted on the next IDLE cycle.

## Timing

- **Reset values:**
  - State IDLE, `ptr`=0, cell=0x00, `cell_zero`=1.
  - `op_ready`=1, `busy`=0.
  - `ram_re`=0, `ram_we`=0.
  - `alu_nochange`=1, `alu_decrement`=0, `alu_increment`=0.
- **Reset behaviour:** takes effect immediately and asynchronously. `ram_re`/`ram_we` are decoded from state, so both drop with `rst_n` low.
- **Reset mid-operation:** the op is aborted. No RAM write occurs unless the EXEC edge completed before reset.
- **Cycle numbering:** transfer edge = edge 0.
  - INC/DEC: READ in cycle 1, WAIT in cycle 2, EXEC in cycle 3 (write at edge 4). `op_ready` is high again in cycle 4, so throughput is 1 op per 4 cycles.
  - PTR_INC/PTR_DEC/LOAD: `ptr` is updated at edge 0 (pointer ops). READ in cycle 1, WAIT in cycle 2. `cell_zero` is valid and `op_ready`=1 in cycle 3.
  - NOP: `op_ready` stays 1; one NOP is accepted per cycle.
- **`cell_zero` during an op:** holds its previous value until the updating edge.

## Test plan

- **Reset:** drop `rst_n` while in EXEC → same cycle `ram_we`=0, `op_ready`=1, `ptr`=0, `cell_zero`=1, `alu_nochange`=1.
- **INC:** RAM[0]=0xAD, INC at edge 0 → `ram_re` in cycle 1; in cycle 3 `alu_increment`=1, `alu_a`=0xAD, `ram_we`=1, `ram_wdata`=0xAE; `op_ready`=1 in cycle 4; `cell_zero`=0.
- **DEC boundaries:**
  - RAM[0]=0x01, DEC → writes 0x00, `cell_zero`=1.
  - Second DEC → writes 0xFF, `cell_zero`=0.
  - INC of 0xFF → 0x00.
- **Pointer wrap:** `ptr`=0, RAM[0xFF]=0x00, PTR_DEC → `ptr`=0xFF after edge 0; read of address 0xFF; `cell_zero`=1 in cycle 3. Then PTR_INC → `ptr`=0x00.
- **Handshake:** `op_valid` held high with op_code=INC, switched to PTR_INC in cycle 2 → only INC is executed during cycles 1–3; PTR_INC is accepted in cycle 4. NOP/6/7 produce no `ram_re`/`ram_we` and never drop `op_ready`.
- **Abort:** reset pulse during WAIT of an INC → no write to RAM[0] (value unchanged when re-read via LOAD); subsequent ops operate normally from `ptr`=0.

Source files
------------

// File: rtl/bf_cell_ctrl.sv
// ---------------------------------------------------------------------------
// bf_cell_ctrl
//
// Data-cell sequencer for the BF CPU. It takes one decoded cell or pointer
// operation at a time from the instruction decoder and carries it out against
// the data RAM and the 8-bit ALU:
//   - INC / DEC : read the cell, run it through the ALU, write it back
//   - PTR_INC / PTR_DEC : move the data pointer, then read the new cell
//   - LOAD : re-read the cell at the current pointer
// The controller tracks whether the current cell is zero (cell_zero) so the
// loop logic can resolve '[' and ']' without touching the RAM itself.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   op_valid, op_code     : operation request (0 NOP, 1 INC, 2 DEC,
//                           3 PTR_INC, 4 PTR_DEC, 5 LOAD, 6-7 NOP)
//   op_ready, busy        : accept handshake, busy = !op_ready
//   ram_addr, ram_re      : RAM address (always ptr) and read strobe;
//                           ram_rdata is valid the cycle after ram_re
//   ram_rdata             : RAM read data
//   ram_we, ram_wdata     : RAM write strobe and data (data = alu_out)
//   alu_a                 : ALU operand (the internal cell register)
//   alu_nochange/decrement/increment : one-hot ALU function select
//   alu_out               : combinational ALU result
//   ptr                   : current data pointer
//   cell_zero             : high when the cell at ptr holds 0x00
// ---------------------------------------------------------------------------
module bf_cell_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    output logic              op_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    output logic [7:0]        alu_a,
    output logic              alu_nochange,
    output logic              alu_decrement,
    output logic              alu_increment,
    input  logic [7:0]        alu_out,
    output logic [ADDR_W-1:0] ptr,
    output logic              cell_zero
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_INC     = 3'd1;
    localparam logic [2:0] OP_DEC     = 3'd2;
    localparam logic [2:0] OP_PTR_INC = 3'd3;
    localparam logic [2:0] OP_PTR_DEC = 3'd4;
    localparam logic [2:0] OP_LOAD    = 3'd5;

    localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_EXEC
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        cell_q, cell_d;
    logic              zero_q, zero_d;

    // State register. The RAM starts zeroed, so cell 0 is known to be zero
    // out of reset and cell_zero comes up high without a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            ptr_q   <= '0;
            cell_q  <= 8'h00;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            cell_q  <= cell_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic. Pointer moves happen on the accept edge so that the
    // READ cycle already addresses the new cell. NOP and undefined codes are
    // consumed in IDLE without leaving it.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ptr_d   = ptr_q;
        cell_d  = cell_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_INC, OP_DEC, OP_LOAD: begin
                            op_d    = op_code;
                            state_d = ST_READ;
                        end
                        OP_PTR_INC: begin
                            op_d    = op_code;
                            ptr_d   = ptr_q + PtrOne;
                            state_d = ST_READ;
                        end
                        OP_PTR_DEC: begin
                            op_d    = op_code;
                            ptr_d   = ptr_q - PtrOne;
                            state_d = ST_READ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // For INC/DEC cell_zero is left alone here and only updated
                // once the modified value is known in EXEC.
                cell_d = ram_rdata;
                if (op_q == OP_INC || op_q == OP_DEC) begin
                    state_d = ST_EXEC;
                end else begin
                    zero_d  = (ram_rdata == 8'h00);
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cell_d  = alu_out;
                zero_d  = (alu_out == 8'h00);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. Strobes come purely from state so an asynchronous reset
    // removes them immediately. EXEC is only entered for INC or DEC, so the
    // ALU select stays one-hot.
    always_comb begin
        op_ready      = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        ram_re        = (state_q == ST_READ);
        ram_we        = (state_q == ST_EXEC);
        alu_nochange  = 1'b1;
        alu_decrement = 1'b0;
        alu_increment = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_nochange = 1'b0;
            if (op_q == OP_DEC) begin
                alu_decrement = 1'b1;
            end else begin
                alu_increment = 1'b1;
            end
        end
    end

    assign ram_addr  = ptr_q;
    assign ptr       = ptr_q;
    assign ram_wdata = alu_out;
    assign alu_a     = cell_q;
    assign cell_zero = zero_q;

endmodule

// File: tb/tb_bf_cell_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bf_cell_ctrl
//
// Directed bench for bf_cell_ctrl. The bench owns a zero-initialised data RAM
// and a behavioural 8-bit ALU. Each operation pushes its hand-computed RAM
// write and completion state (ptr, cell_zero) into queues; a monitor on the
// falling edge pops and compares whenever the DUT writes the RAM or returns
// to ready after being busy. Cycle-level and reset checks are made inline.
// ---------------------------------------------------------------------------
module tb_bf_cell_ctrl;

    localparam int ADDR_W = 8;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_INC     = 3'd1;
    localparam logic [2:0] OP_DEC     = 3'd2;
    localparam logic [2:0] OP_PTR_INC = 3'd3;
    localparam logic [2:0] OP_PTR_DEC = 3'd4;
    localparam logic [2:0] OP_LOAD    = 3'd5;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wrExp_t;

    typedef struct packed {
        logic [7:0] ptrVal;
        logic       zero;
    } doneExp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              op_valid = 1'b0;
    logic [2:0]        op_code = 3'd0;
    logic              op_ready;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic [7:0]        ramRdata = 8'h00;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        alu_a;
    logic              alu_nochange;
    logic              alu_decrement;
    logic              alu_increment;
    logic [7:0]        aluOut;
    logic [ADDR_W-1:0] ptr;
    logic              cell_zero;

    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic       pokeEn = 1'b0;
    logic [7:0] pokeAddr = 8'h00;
    logic [7:0] pokeData = 8'h00;

    wrExp_t   writeQ [$];
    doneExp_t doneQ [$];
    wrExp_t   wPop;
    doneExp_t dPop;
    logic     prevBusy = 1'b0;

    logic [2:0] nopCodes [4] = '{3'd0, 3'd6, 3'd7, 3'd0};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bf_cell_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .op_ready      (op_ready),
        .busy          (busy),
        .ram_addr      (ram_addr),
        .ram_re        (ram_re),
        .ram_rdata     (ramRdata),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .alu_a         (alu_a),
        .alu_nochange  (alu_nochange),
        .alu_decrement (alu_decrement),
        .alu_increment (alu_increment),
        .alu_out       (aluOut),
        .ptr           (ptr),
        .cell_zero     (cell_zero)
    );

    // Behavioural ALU: 8-bit wrap-around increment/decrement.
    always_comb begin
        aluOut = alu_a;
        if (alu_increment) begin
            aluOut = alu_a + 8'd1;
        end else if (alu_decrement) begin
            aluOut = alu_a - 8'd1;
        end
    end

    // Data RAM with one-cycle read latency; bench pokes only while idle.
    always @(posedge clk) begin
        if (ram_re) begin
            ramRdata <= mem[ram_addr];
        end
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares RAM writes and op completions against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevBusy = 1'b0;
        end else begin
            if (ram_we) begin
                if (writeQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             ram_addr, ram_wdata);
                end else begin
                    wPop = writeQ.pop_front();
                    checkOutput("ram_write", 32'({ram_addr, ram_wdata}), 32'({wPop.addr, wPop.data}));
                end
            end
            if (op_ready && prevBusy) begin
                if (doneQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got ptr 0x%0h expected no completion", ptr);
                end else begin
                    dPop = doneQ.pop_front();
                    checkOutput("done_ptr", 32'(ptr), 32'(dPop.ptrVal));
                    checkOutput("done_cell_zero", 32'(cell_zero), 32'(dPop.zero));
                end
            end
            prevBusy = busy;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pokeMem(input logic [7:0] a, input logic [7:0] dat);
        pokeAddr = a;
        pokeData = dat;
        pokeEn   = 1'b1;
        nextCycle();
        pokeEn   = 1'b0;
    endtask

    task automatic issueOp(input logic [2:0] code);
        op_valid = 1'b1;
        op_code  = code;
        nextCycle();
        op_valid = 1'b0;
        op_code  = OP_NOP;
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (!op_ready && n < 20) begin
            nextCycle();
            n++;
        end
        if (!op_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got op_ready 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic pushWrite(input logic [7:0] a, input logic [7:0] dat);
        wrExp_t e;
        e.addr = a;
        e.data = dat;
        writeQ.push_back(e);
    endtask

    task automatic pushDone(input logic [7:0] p, input logic z);
        doneExp_t e;
        e.ptrVal = p;
        e.zero   = z;
        doneQ.push_back(e);
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] code,
                                 input logic expWrite, input logic [7:0] wAddr,
                                 input logic [7:0] wData, input logic [7:0] dPtr,
                                 input logic dZero);
        if (expWrite) begin
            pushWrite(wAddr, wData);
        end
        pushDone(dPtr, dZero);
        issueOp(code);
        waitReady(name);
    endtask

    // Reset held into the next falling edge, released well clear of a rising edge.
    task automatic releaseReset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_op_ready", 32'(op_ready), 32'(1));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_ptr", 32'(ptr), 32'(0));
        checkOutput("rst_cell_zero", 32'(cell_zero), 32'(1));
        checkOutput("rst_ram_re", 32'(ram_re), 32'(0));
        checkOutput("rst_ram_we", 32'(ram_we), 32'(0));
        checkOutput("rst_alu_sel", 32'({alu_nochange, alu_decrement, alu_increment}), 32'(3'b100));
        checkOutput("rst_alu_a", 32'(alu_a), 32'(8'h00));
        releaseReset();

        // INC of 0xAD with cycle-by-cycle timing.
        pokeMem(8'h00, 8'hAD);
        pushWrite(8'h00, 8'hAE);
        pushDone(8'h00, 1'b0);
        issueOp(OP_INC);
        checkOutput("inc_c1_ram_re", 32'(ram_re), 32'(1));
        checkOutput("inc_c1_ram_addr", 32'(ram_addr), 32'(0));
        checkOutput("inc_c1_busy", 32'({op_ready, busy}), 32'(2'b01));
        nextCycle();
        checkOutput("inc_c2_strobes", 32'({ram_re, ram_we}), 32'(2'b00));
        nextCycle();
        checkOutput("inc_c3_ram_we", 32'(ram_we), 32'(1));
        checkOutput("inc_c3_alu_sel", 32'({alu_nochange, alu_decrement, alu_increment}), 32'(3'b001));
        checkOutput("inc_c3_alu_a", 32'(alu_a), 32'(8'hAD));
        checkOutput("inc_c3_wdata", 32'(ram_wdata), 32'(8'hAE));
        checkOutput("inc_c3_zero_held", 32'(cell_zero), 32'(1));
        nextCycle();
        checkOutput("inc_c4_op_ready", 32'(op_ready), 32'(1));
        checkOutput("inc_c4_cell_zero", 32'(cell_zero), 32'(0));

        // DEC / INC boundaries.
        pokeMem(8'h00, 8'h01);
        applyStimulus("dec_to_zero", OP_DEC, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        applyStimulus("dec_wrap", OP_DEC, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
        applyStimulus("inc_wrap", OP_INC, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        pokeMem(8'h00, 8'h10);
        applyStimulus("load", OP_LOAD, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Pointer wrap downwards, then back up.
        pushDone(8'hFF, 1'b1);
        issueOp(OP_PTR_DEC);
        checkOutput("pdec_c1_ptr", 32'(ptr), 32'(8'hFF));
        checkOutput("pdec_c1_read", 32'({ram_re, ram_addr}), 32'({1'b1, 8'hFF}));
        nextCycle();
        checkOutput("pdec_c2_op_ready", 32'(op_ready), 32'(0));
        checkOutput("pdec_c2_zero_held", 32'(cell_zero), 32'(0));
        nextCycle();
        checkOutput("pdec_c3_op_ready", 32'(op_ready), 32'(1));
        checkOutput("pdec_c3_cell_zero", 32'(cell_zero), 32'(1));
        applyStimulus("pinc_wrap", OP_PTR_INC, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus("pinc_one", OP_PTR_INC, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
        applyStimulus("inc_ptr1", OP_INC, 1'b1, 8'h01, 8'h01, 8'h01, 1'b0);

        // Reset while in EXEC: strobes drop at once and nothing is written.
        issueOp(OP_INC);
        nextCycle();
        nextCycle();
        checkOutput("abort_exec_reached", 32'(ram_we), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_exec_ram_we", 32'(ram_we), 32'(0));
        checkOutput("abort_exec_ready", 32'({op_ready, busy}), 32'(2'b10));
        checkOutput("abort_exec_ptr", 32'(ptr), 32'(0));
        checkOutput("abort_exec_cell_zero", 32'(cell_zero), 32'(1));
        checkOutput("abort_exec_alu_sel", 32'({alu_nochange, alu_decrement, alu_increment}), 32'(3'b100));
        releaseReset();
        checkOutput("abort_exec_mem1", 32'(mem[8'h01]), 32'(8'h01));

        // Held request: INC held, switched to PTR_INC mid-op.
        pushWrite(8'h00, 8'h11);
        pushDone(8'h00, 1'b0);
        pushDone(8'h01, 1'b0);
        op_valid = 1'b1;
        op_code  = OP_INC;
        nextCycle();
        checkOutput("hold_c1_op_ready", 32'(op_ready), 32'(0));
        nextCycle();
        op_code = OP_PTR_INC;
        checkOutput("hold_c2_ptr", 32'(ptr), 32'(0));
        nextCycle();
        checkOutput("hold_c3_ptr", 32'(ptr), 32'(0));
        nextCycle();
        checkOutput("hold_c4_op_ready", 32'(op_ready), 32'(1));
        checkOutput("hold_c4_ptr", 32'(ptr), 32'(0));
        nextCycle();
        op_valid = 1'b0;
        op_code  = OP_NOP;
        checkOutput("hold_accept_ptr", 32'(ptr), 32'(1));
        checkOutput("hold_accept_busy", 32'(busy), 32'(1));
        waitReady("hold_pinc");

        // NOP and undefined codes: accepted each cycle, no side effects.
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1;
            op_code  = nopCodes[i];
            nextCycle();
            checkOutput("nop_op_ready", 32'(op_ready), 32'(1));
            checkOutput("nop_strobes", 32'({ram_re, ram_we}), 32'(2'b00));
        end
        op_valid = 1'b0;
        op_code  = OP_NOP;
        checkOutput("nop_ptr", 32'(ptr), 32'(1));

        // Reset during WAIT of an INC: RAM[0] keeps 0x11.
        applyStimulus("pdec_to0", OP_PTR_DEC, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        issueOp(OP_INC);
        nextCycle();
        checkOutput("abort_wait_state", 32'({op_ready, ram_re, ram_we}), 32'(3'b000));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_wait_ready", 32'(op_ready), 32'(1));
        releaseReset();
        checkOutput("abort_wait_mem0", 32'(mem[8'h00]), 32'(8'h11));
        applyStimulus("reload", OP_LOAD, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus("inc_after_abort", OP_INC, 1'b1, 8'h00, 8'h12, 8'h00, 1'b0);

        repeat (5) nextCycle();
        checkOutput("writeQ_drained", 32'(writeQ.size()), 32'(0));
        checkOutput("doneQ_drained", 32'(doneQ.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
